// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: register tags and control from the datapath,
// forwarding selects and stall/flush enables back to the pipeline.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       RA1D;
  logic [3:0]       RA2D;
  logic [3:0]       RA1E;
  logic [3:0]       RA2E;
  logic [3:0]       WA3E;
  logic             RegWriteE;
  logic             MemtoRegE;
  logic [3:0]       WA3M;
  logic             RegWriteM;
  logic [3:0]       WA3W;
  logic             RegWriteW;
  logic             BranchTakenE;
  logic             MemReqM;
  logic             MemReadyM;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             StallE;
  logic             StallM;
  logic             FlushD;
  logic             FlushE;
  logic             FlushW;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E,
    output RegWriteE, MemtoRegE,
    output WA3M, RegWriteM, WA3W, RegWriteW,
    output BranchTakenE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE,
    input  StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW,
    input  MemTimeout, StallCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E,
    input  RegWriteE, MemtoRegE,
    input  WA3M, RegWriteM, WA3W, RegWriteW,
    input  BranchTakenE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE,
    output StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW,
    output MemTimeout, StallCount
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer: Execute forwarding, load-use stall, branch flush,
// data-memory wait freeze with timeout, and a stall-cycle statistic.
module hazard_controller #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hz
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic {
    RUN,
    MEMWAIT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WW-1:0]    wcnt_q;
  logic [WW-1:0]    wcnt_d;
  logic             tmo_q;
  logic             tmo_set;
  logic [CNT_W-1:0] scnt_q;

  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       stall_m;
  logic       flush_d;
  logic       flush_e;
  logic       flush_w;
  logic       load_use;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  // M-stage result beats W-stage; R15 reads PC+8 and is never forwarded
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra);
    if (hz.RegWriteM && hz.WA3M == ra && hz.WA3M != 4'd15)
      return 2'b10;
    else if (hz.RegWriteW && hz.WA3W == ra && hz.WA3W != 4'd15)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // forwarding selects for both Execute operands
  always_comb begin
    fwd_a = fwd_sel(hz.RA1E);
    fwd_b = fwd_sel(hz.RA2E);
  end

  assign load_use = hz.MemtoRegE && hz.RegWriteE &&
                    hz.WA3E != 4'd15 &&
                    (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);

  // next state, wait counter and stall/flush decode
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tmo_set = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          stall_m = 1'b1;
          flush_w = 1'b1;
          state_d = MEMWAIT;
          wcnt_d  = WW'(1);
        end else if (hz.BranchTakenE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MEMWAIT: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
        if (hz.MemReadyM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else if (wcnt_q == WW'(MAX_WAIT)) begin
          tmo_set = 1'b1;
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (tmo_set)
        tmo_q <= 1'b1;
    end
  end

  // saturating count of cycles with the PC held
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      scnt_q <= '0;
    else if (stall_f && scnt_q != {CNT_W{1'b1}})
      scnt_q <= scnt_q + CNT_W'(1);
  end

  assign hz.ForwardAE  = rst ? 2'b00 : fwd_a;
  assign hz.ForwardBE  = rst ? 2'b00 : fwd_b;
  assign hz.StallF     = stall_f & ~rst;
  assign hz.StallD     = stall_d & ~rst;
  assign hz.StallE     = stall_e & ~rst;
  assign hz.StallM     = stall_m & ~rst;
  assign hz.FlushD     = flush_d & ~rst;
  assign hz.FlushE     = flush_e & ~rst;
  assign hz.FlushW     = flush_w & ~rst;
  assign hz.MemTimeout = tmo_q & ~rst;
  assign hz.StallCount = rst ? '0 : scnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: forwarding, load-use, branch,
// memory wait, timeout and mid-wait reset.
module tb_hazard_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(16)) hz ();

  hazard_controller #(
    .MAX_WAIT(16),
    .CNT_W   (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  task automatic idle();
    hz.RA1D = 4'd0; hz.RA2D = 4'd0;
    hz.RA1E = 4'd0; hz.RA2E = 4'd0;
    hz.WA3E = 4'd0; hz.RegWriteE = 1'b0;
    hz.MemtoRegE = 1'b0;
    hz.WA3M = 4'd0; hz.RegWriteM = 1'b0;
    hz.WA3W = 4'd0; hz.RegWriteW = 1'b0;
    hz.BranchTakenE = 1'b0;
    hz.MemReqM = 1'b0; hz.MemReadyM = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    hz.RegWriteM = 1'b1; hz.WA3M = 4'd1; hz.RA1E = 4'd1;
    hz.MemReqM = 1'b1;
    #1;
    nvec++;
    if (hz.ForwardAE !== 2'b00) begin
      nerr++;
      $display("FAIL rst_fwd got=%b exp=00", hz.ForwardAE);
    end
    nvec++;
    if (hz.StallF !== 1'b0 || hz.FlushW !== 1'b0) begin
      nerr++;
      $display("FAIL rst_stall got=%b%b exp=00", hz.StallF, hz.FlushW);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    nvec++;
    if (hz.StallCount !== 16'd0 || hz.MemTimeout !== 1'b0) begin
      nerr++;
      $display("FAIL rst_cnt got=%0d/%b exp=0/0",
               hz.StallCount, hz.MemTimeout);
    end
  endtask

  task automatic test_forward();
    logic [3:0] ra1 [6];
    logic [3:0] ra2 [6];
    logic       rwm [6];
    logic [3:0] wam [6];
    logic       rww [6];
    logic [3:0] waw [6];
    logic [1:0] ea  [6];
    logic [1:0] eb  [6];
    ra1 = '{4'd1, 4'd1, 4'd15, 4'd5, 4'd7, 4'd2};
    ra2 = '{4'd0, 4'd3, 4'd15, 4'd5, 4'd7, 4'd9};
    rwm = '{1'b1, 1'b1, 1'b1,  1'b0, 1'b1, 1'b1};
    wam = '{4'd1, 4'd1, 4'd15, 4'd5, 4'd7, 4'd9};
    rww = '{1'b0, 1'b1, 1'b1,  1'b1, 1'b1, 1'b1};
    waw = '{4'd0, 4'd1, 4'd15, 4'd5, 4'd7, 4'd2};
    ea  = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01};
    eb  = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      idle();
      hz.RA1E = ra1[i]; hz.RA2E = ra2[i];
      hz.RegWriteM = rwm[i]; hz.WA3M = wam[i];
      hz.RegWriteW = rww[i]; hz.WA3W = waw[i];
      #1;
      nvec++;
      if (hz.ForwardAE !== ea[i] || hz.ForwardBE !== eb[i]) begin
        nerr++;
        $display("FAIL fwd[%0d] got=%b/%b exp=%b/%b",
                 i, hz.ForwardAE, hz.ForwardBE, ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle();
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1;
    hz.WA3E = 4'd2; hz.RA2D = 4'd2;
    #1;
    nvec++;
    if ({hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushD}
        !== 5'b11100) begin
      nerr++;
      $display("FAIL load_use got=%b exp=11100",
               {hz.StallF, hz.StallD, hz.FlushE, hz.StallE, hz.FlushD});
    end
    @(negedge clk);
    idle();
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b0;
    hz.WA3E = 4'd2; hz.RA1D = 4'd2;
    #1;
    nvec++;
    if (hz.StallF !== 1'b0 || hz.StallCount !== 16'd1) begin
      nerr++;
      $display("FAIL load_use_once got=%b/%0d exp=0/1",
               hz.StallF, hz.StallCount);
    end
    @(negedge clk);
    idle();
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1;
    hz.WA3E = 4'd15; hz.RA1D = 4'd15;
    #1;
    nvec++;
    if (hz.StallF !== 1'b0 || hz.FlushE !== 1'b0) begin
      nerr++;
      $display("FAIL load_use_r15 got=%b%b exp=00", hz.StallF, hz.FlushE);
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    idle();
    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1;
    hz.WA3E = 4'd4; hz.RA1D = 4'd4;
    hz.BranchTakenE = 1'b1;
    #1;
    nvec++;
    if ({hz.FlushD, hz.FlushE, hz.StallF, hz.StallD} !== 4'b1100) begin
      nerr++;
      $display("FAIL branch got=%b exp=1100",
               {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD});
    end
    @(negedge clk);
    idle();
    #1;
    nvec++;
    if (hz.StallCount !== 16'd1) begin
      nerr++;
      $display("FAIL branch_cnt got=%0d exp=1", hz.StallCount);
    end
  endtask

  task automatic test_memwait();
    logic rdy [4];
    logic br  [4];
    rdy = '{1'b0, 1'b0, 1'b0, 1'b1};
    br  = '{1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle();
      hz.MemReqM = 1'b1; hz.MemReadyM = rdy[i];
      hz.BranchTakenE = br[i];
      #1;
      nvec++;
      if ({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushW,
           hz.FlushD} !== 6'b111110) begin
        nerr++;
        $display("FAIL memwait[%0d] got=%b exp=111110", i,
                 {hz.StallF, hz.StallD, hz.StallE, hz.StallM,
                  hz.FlushW, hz.FlushD});
      end
    end
    @(negedge clk);
    idle();
    #1;
    nvec++;
    if (hz.StallM !== 1'b0 || hz.StallCount !== 16'd5 ||
        hz.MemTimeout !== 1'b0) begin
      nerr++;
      $display("FAIL memwait_done got=%b/%0d/%b exp=0/5/0",
               hz.StallM, hz.StallCount, hz.MemTimeout);
    end
    @(negedge clk);
    idle();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1;
    #1;
    nvec++;
    if (hz.StallF !== 1'b0 || hz.FlushW !== 1'b0) begin
      nerr++;
      $display("FAIL mem_1cyc got=%b%b exp=00", hz.StallF, hz.FlushW);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      idle();
      hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    end
    #1;
    nvec++;
    if (hz.MemTimeout !== 1'b0 || hz.StallM !== 1'b1) begin
      nerr++;
      $display("FAIL tmo_early got=%b/%b exp=0/1",
               hz.MemTimeout, hz.StallM);
    end
    @(negedge clk);
    idle();
    #1;
    nvec++;
    if (hz.MemTimeout !== 1'b1 || hz.StallF !== 1'b0 ||
        hz.StallCount !== 16'd22) begin
      nerr++;
      $display("FAIL tmo got=%b/%b/%0d exp=1/0/22",
               hz.MemTimeout, hz.StallF, hz.StallCount);
    end
    @(negedge clk);
    #1;
    nvec++;
    if (hz.MemTimeout !== 1'b1) begin
      nerr++;
      $display("FAIL tmo_sticky got=%b exp=1", hz.MemTimeout);
    end
  endtask

  task automatic test_rst_midwait();
    @(negedge clk);
    idle();
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    nvec++;
    if ({hz.StallF, hz.StallM, hz.FlushW, hz.MemTimeout} !== 4'b0000 ||
        hz.StallCount !== 16'd0) begin
      nerr++;
      $display("FAIL rst_mid got=%b/%0d exp=0000/0",
               {hz.StallF, hz.StallM, hz.FlushW, hz.MemTimeout},
               hz.StallCount);
    end
    @(negedge clk);
    rst = 1'b0;
    hz.MemReqM = 1'b1; hz.MemReadyM = 1'b1;
    #1;
    nvec++;
    if (hz.StallF !== 1'b0 || hz.StallCount !== 16'd0 ||
        hz.MemTimeout !== 1'b0) begin
      nerr++;
      $display("FAIL rst_run got=%b/%0d/%b exp=0/0/0",
               hz.StallF, hz.StallCount, hz.MemTimeout);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_memwait();
    test_timeout();
    test_rst_midwait();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
